// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered program counter with boot, stall, redirect bubble and redirect counter

module pc_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               STEP     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             flush,
  output logic             misaligned,
  output logic [7:0]       redirect_count
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pc_next;
  logic             pc_valid_next;
  logic             flush_next;
  logic             misaligned_next;
  logic [7:0]       count_next;

  // Target with the low two bits forced to zero; fetch is always word aligned.
  logic [WIDTH-1:0] target_aligned;
  logic             target_low_nonzero;
  logic [7:0]       count_sat_inc;

  // Alignment and saturating-increment helpers shared by RUN and REDIRECT accepts.
  always_comb begin
    target_aligned     = {br_target[WIDTH-1:2], 2'b00};
    target_low_nonzero = (br_target[1:0] != 2'b00);
    count_sat_inc      = (redirect_count == 8'hFF) ? redirect_count : redirect_count + 8'd1;
  end

  // Next-state and next-output decode; flush and misaligned are single-cycle pulses by default.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    pc_valid_next   = pc_valid;
    flush_next      = 1'b0;
    misaligned_next = 1'b0;
    count_next      = redirect_count;

    case (state)
      BOOT: begin
        // One settle cycle after reset; branch and stall requests are ignored.
        state_next    = RUN;
        pc_next       = RESET_PC;
        pc_valid_next = 1'b1;
      end

      RUN: begin
        if (br_taken) begin
          // Redirect wins over stall.
          state_next      = REDIRECT;
          pc_next         = target_aligned;
          pc_valid_next   = 1'b0;
          flush_next      = 1'b1;
          misaligned_next = target_low_nonzero;
          count_next      = count_sat_inc;
        end else if (stall) begin
          pc_next       = pc;
          pc_valid_next = pc_valid;
        end else begin
          // Wrap past the top of the address space is silent.
          pc_next       = pc + STEP_W;
          pc_valid_next = 1'b1;
        end
      end

      REDIRECT: begin
        if (br_taken) begin
          // A fresh redirect during the bubble restarts the bubble.
          state_next      = REDIRECT;
          pc_next         = target_aligned;
          pc_valid_next   = 1'b0;
          flush_next      = 1'b1;
          misaligned_next = target_low_nonzero;
          count_next      = count_sat_inc;
        end else begin
          // Bubble done; the held target becomes fetchable. Stall has no effect here.
          state_next    = RUN;
          pc_valid_next = 1'b1;
        end
      end

      default: begin
        state_next    = BOOT;
        pc_next       = RESET_PC;
        pc_valid_next = 1'b0;
        count_next    = 8'd0;
      end
    endcase
  end

  // State and output registers; reset overrides any concurrent request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      pc_valid       <= 1'b0;
      flush          <= 1'b0;
      misaligned     <= 1'b0;
      redirect_count <= 8'd0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      pc_valid       <= pc_valid_next;
      flush          <= flush_next;
      misaligned     <= misaligned_next;
      redirect_count <= count_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed self-checking bench for pc_sequencer

module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        misaligned;
  logic [7:0]  redirect_count;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0), .STEP(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .flush          (flush),
    .misaligned     (misaligned),
    .redirect_count (redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: "phase" counts where we are in the boot/bubble timeline.
  // 0 = just reset, 1 = fetching, 2 = waiting out a redirect bubble.
  int          m_phase;
  bit          m_known = 0;
  longint      m_pc;
  bit          m_valid;
  bit          m_flush;
  bit          m_mis;
  int          m_count;

  always @(posedge clk) begin
    if (reset) begin
      m_known = 1;
      m_phase = 0;
      m_pc    = 0;
      m_valid = 0;
      m_flush = 0;
      m_mis   = 0;
      m_count = 0;
    end else if (m_known) begin
      m_flush = 0;
      m_mis   = 0;
      if (m_phase == 0) begin
        m_phase = 1;
        m_valid = 1;
      end else if (br_taken) begin
        m_pc    = (longint'(br_target) / 4) * 4;
        m_mis   = (br_target % 4) != 0;
        m_flush = 1;
        m_valid = 0;
        m_count = (m_count + 1 > 255) ? 255 : m_count + 1;
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 1;
        m_valid = 1;
      end else if (!stall) begin
        m_pc = (m_pc + 4) % 64'h1_0000_0000;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_known) begin
      chk("pc",             longint'(pc),             m_pc);
      chk("pc_valid",       longint'(pc_valid),       longint'(m_valid));
      chk("flush",          longint'(flush),          longint'(m_flush));
      chk("misaligned",     longint'(misaligned),     longint'(m_mis));
      chk("redirect_count", longint'(redirect_count), longint'(m_count));
    end
  end

  task automatic cyc(input bit r, input bit s, input bit b, input logic [31:0] t);
    reset     = r;
    stall     = s;
    br_taken  = b;
    br_target = t;
    @(negedge clk);
  endtask

  initial begin
    reset = 1; stall = 0; br_taken = 0; br_target = 0;
    // Reset then boot
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("lit_boot_pc", pc, 0);
    chk("lit_boot_valid", pc_valid, 0);
    cyc(0, 0, 0, 0);
    chk("lit_run_pc0", pc, 0);
    chk("lit_run_valid0", pc_valid, 1);
    cyc(0, 0, 0, 0);
    chk("lit_run_pc4", pc, 4);
    cyc(0, 0, 0, 0);
    chk("lit_run_pc8", pc, 8);
    // Stall at 8 for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("lit_stall_pc", pc, 8);
      chk("lit_stall_valid", pc_valid, 1);
    end
    cyc(0, 0, 0, 0);
    chk("lit_after_stall_pc", pc, 12);
    // Branch beats stall
    cyc(0, 1, 1, 32'h100);
    chk("lit_br_pc", pc, 32'h100);
    chk("lit_br_valid", pc_valid, 0);
    chk("lit_br_flush", flush, 1);
    chk("lit_br_count", redirect_count, 1);
    cyc(0, 0, 0, 0);
    chk("lit_bubble_pc", pc, 32'h100);
    chk("lit_bubble_valid", pc_valid, 1);
    chk("lit_bubble_flush", flush, 0);
    cyc(0, 0, 0, 0);
    chk("lit_post_br_pc", pc, 32'h104);
    // Back-to-back redirect with misaligned target
    cyc(0, 0, 1, 32'h200);
    chk("lit_b2b_flush1", flush, 1);
    chk("lit_b2b_mis1", misaligned, 0);
    cyc(0, 0, 1, 32'h303);
    chk("lit_b2b_pc", pc, 32'h300);
    chk("lit_b2b_flush2", flush, 1);
    chk("lit_b2b_mis2", misaligned, 1);
    chk("lit_b2b_count", redirect_count, 3);
    cyc(0, 0, 0, 0);
    chk("lit_b2b_valid", pc_valid, 1);
    chk("lit_b2b_pc_valid_at", pc, 32'h300);
    chk("lit_b2b_mis_clear", misaligned, 0);
    // Silent wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("lit_wrap_top", pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("lit_wrap_pc", pc, 0);
    chk("lit_wrap_mis", misaligned, 0);
    // Saturation
    for (int i = 0; i < 260; i++) cyc(0, 0, 1, $urandom);
    chk("lit_sat_count", redirect_count, 255);
    // Reset in the redirect bubble with a concurrent branch
    cyc(1, 0, 1, 32'h400);
    chk("lit_rst_pc", pc, 0);
    chk("lit_rst_valid", pc_valid, 0);
    chk("lit_rst_flush", flush, 0);
    chk("lit_rst_count", redirect_count, 0);
    cyc(0, 1, 1, 32'h500);
    chk("lit_rst_boot_ignores_br", pc, 0);
    chk("lit_rst_boot_valid", pc_valid, 1);
    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 4) == 0), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
